// File: rtl/mm_ctrl.sv
// mm_ctrl: control and sequencing for the 4x4 matrix-multiply engine (ap_ctrl register,
// stream gating, buffer addressing, MAC sequencing). Optional MM_CYCLE_CNT_EN adds a run-cycle counter at 0x10.
module mm_ctrl #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  input  logic                   ss_tvalid,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  output logic                   buf_we,
  output logic [4:0]             buf_waddr,
  output logic [3:0]             rd_a_addr,
  output logic [3:0]             rd_b_addr,
  output logic                   mac_clr,
  output logic                   mac_en,
  output logic                   sm_tvalid,
  output logic                   sm_tlast,
  input  logic                   sm_tready
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_OUT, S_DONE} state_e;

  localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;

  state_e                 state_q, state_d;
  logic [4:0]             beat_q, beat_d;
  logic [3:0]             elem_q, elem_d;
  logic [2:0]             cyc_q, cyc_d;
  logic                   ap_start_q, ap_start_d;
  logic                   ap_done_q, ap_done_d;
  logic                   ap_idle_q, ap_idle_d;
  logic                   err_q, err_d;
  logic                   wr_ack_q, wr_ack_d;
  logic                   rd_ack_q, rd_ack_d;
  logic                   rvalid_q, rvalid_d;
  logic [pDATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [pDATA_WIDTH-1:0] rd_mux;
  logic                   wr_fire, rd_fire;
  logic                   wdata_unused;

`ifdef MM_CYCLE_CNT_EN
  localparam logic [pADDR_WIDTH-1:0] ADDR_CNT = pADDR_WIDTH'(16);
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE && ap_start_q) cnt_d = '0;
    else if (state_q != S_IDLE)          cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) cnt_q <= '0;
    else             cnt_q <= cnt_d;
  end
`endif

  // Only ap_start is writable; the remaining write-data bits are ignored.
  assign wdata_unused = ^wdata[pDATA_WIDTH-1:1];

  assign wr_fire   = wr_ack_q && awvalid && wvalid;
  assign rd_fire   = rd_ack_q && arvalid;
  assign awready   = wr_ack_q;
  assign wready    = wr_ack_q;
  assign arready   = rd_ack_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign buf_waddr = beat_q;

  always_comb begin
    rd_mux = '0;
    if (araddr == ADDR_CTRL) rd_mux = pDATA_WIDTH'({err_q, ap_idle_q, ap_done_q, ap_start_q});
`ifdef MM_CYCLE_CNT_EN
    else if (araddr == ADDR_CNT) rd_mux = pDATA_WIDTH'(cnt_q);
`endif
  end

  always_comb begin
    // NOTE: every _d and every output gets a default first, so no branch can infer a latch.
    state_d    = state_q;
    beat_d     = beat_q;
    elem_d     = elem_q;
    cyc_d      = cyc_q;
    ap_start_d = ap_start_q;
    ap_done_d  = ap_done_q;
    ap_idle_d  = ap_idle_q;
    err_d      = err_q;
    wr_ack_d   = awvalid && wvalid && !wr_ack_q;
    rd_ack_d   = arvalid && !rd_ack_q && !rvalid_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    ss_tready  = 1'b0;
    buf_we     = 1'b0;
    rd_a_addr  = '0;
    rd_b_addr  = '0;
    mac_clr    = 1'b0;
    mac_en     = 1'b0;
    sm_tvalid  = 1'b0;
    sm_tlast   = 1'b0;

    if (wr_fire && awaddr == ADDR_CTRL && state_q == S_IDLE && wdata[0]) ap_start_d = 1'b1;

    if (rvalid_q && rready) rvalid_d = 1'b0;
    // Clear-on-read happens after capture; FSM sets below take priority on a collision.
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_mux;
      if (araddr == ADDR_CTRL) begin
        ap_done_d = 1'b0;
        err_d     = 1'b0;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (ap_start_q) begin
          state_d    = S_LOAD;
          ap_start_d = 1'b0;
          ap_idle_d  = 1'b0;
          ap_done_d  = 1'b0;
          beat_d     = '0;
        end
      end
      S_LOAD: begin
        ss_tready = 1'b1;
        if (ss_tvalid) begin
          buf_we = 1'b1;
          beat_d = beat_q + 5'd1;
          if (ss_tlast != (beat_q == 5'd31)) err_d = 1'b1;
          if (beat_q == 5'd31) begin
            state_d = S_CALC;
            elem_d  = '0;
            cyc_d   = '0;
          end
        end
      end
      S_CALC: begin
        // Reads issue on cycles 0..3; the MAC consumes them one cycle later.
        if (cyc_q != 3'd4) begin
          rd_a_addr = {cyc_q[1:0], elem_q[1:0]};
          rd_b_addr = {elem_q[3:2], cyc_q[1:0]};
        end
        mac_en  = (cyc_q != 3'd0);
        mac_clr = (cyc_q == 3'd1);
        cyc_d   = cyc_q + 3'd1;
        if (cyc_q == 3'd4) state_d = S_OUT;
      end
      S_OUT: begin
        sm_tvalid = 1'b1;
        sm_tlast  = (elem_q == 4'd15);
        if (sm_tready) begin
          if (elem_q == 4'd15) begin
            state_d = S_DONE;
          end else begin
            state_d = S_CALC;
            elem_d  = elem_q + 4'd1;
            cyc_d   = '0;
          end
        end
      end
      S_DONE: begin
        ap_done_d = 1'b1;
        ap_idle_d = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q    <= S_IDLE;
      beat_q     <= '0;
      elem_q     <= '0;
      cyc_q      <= '0;
      ap_start_q <= 1'b0;
      ap_done_q  <= 1'b0;
      ap_idle_q  <= 1'b1;
      err_q      <= 1'b0;
      wr_ack_q   <= 1'b0;
      rd_ack_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      elem_q     <= elem_d;
      cyc_q      <= cyc_d;
      ap_start_q <= ap_start_d;
      ap_done_q  <= ap_done_d;
      ap_idle_q  <= ap_idle_d;
      err_q      <= err_d;
      wr_ack_q   <= wr_ack_d;
      rd_ack_q   <= rd_ack_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_mm_ctrl.sv
// tb_mm_ctrl: self-checking bench for mm_ctrl; models buffer + MAC datapath from the control outputs
// and scores the 16 results of each run against a golden B*A.
module tb_mm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        awvalid, awready, wvalid, wready;
  logic [11:0] awaddr;
  logic [31:0] wdata;
  logic        arvalid, arready, rvalid, rready;
  logic [11:0] araddr;
  logic [31:0] rdata;
  logic        ss_tvalid, ss_tlast, ss_tready;
  logic [31:0] ss_tdata;
  logic        buf_we;
  logic [4:0]  buf_waddr;
  logic [3:0]  rd_a_addr, rd_b_addr;
  logic        mac_clr, mac_en, sm_tvalid, sm_tlast, sm_tready;

  always #5 clk = ~clk;

  mm_ctrl #(.pADDR_WIDTH(12), .pDATA_WIDTH(32)) dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .ss_tvalid(ss_tvalid), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .buf_we(buf_we), .buf_waddr(buf_waddr),
    .rd_a_addr(rd_a_addr), .rd_b_addr(rd_b_addr),
    .mac_clr(mac_clr), .mac_en(mac_en),
    .sm_tvalid(sm_tvalid), .sm_tlast(sm_tlast), .sm_tready(sm_tready)
  );

  typedef struct packed {
    logic        last;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Datapath model: 32-word buffer, 1-cycle read registers, accumulator.
  logic [31:0] mem [32];
  logic [31:0] a_q, b_q, acc;
  int          n_we  = 0;
  int          n_out = 0;
  logic        hold_pending = 1'b0;
  logic        last_prev    = 1'b0;

  always @(posedge clk) begin
    if (buf_we) begin
      mem[buf_waddr] <= ss_tdata;
      n_we <= n_we + 1;
    end
    a_q <= mem[{1'b0, rd_a_addr}];
    b_q <= mem[{1'b1, rd_b_addr}];
    if (mac_en) acc <= mac_clr ? a_q * b_q : acc + a_q * b_q;
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_pending <= 1'b0;
    end else begin
      if (hold_pending) begin
        check("tvalid_hold", sm_tvalid, 1);
        check("tlast_hold", sm_tlast, last_prev);
      end
      if (sm_tvalid && sm_tready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("result", acc, e.val);
          check("tlast", sm_tlast, e.last);
        end
        n_out <= n_out + 1;
      end
      hold_pending <= sm_tvalid && !sm_tready;
      last_prev    <= sm_tlast;
    end
  end

  task automatic axi_write(input logic [11:0] addr, input logic [31:0] data);
    bit ok = 0;
    @(posedge clk); #1;
    awvalid = 1; wvalid = 1; awaddr = addr; wdata = data;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1; break; end
    end
    check("wr_handshake", ok, 1);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
  endtask

  task automatic axi_read(input logic [11:0] addr, output logic [31:0] data);
    bit ok = 0;
    data = '0;
    @(posedge clk); #1;
    arvalid = 1; araddr = addr;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    arvalid = 0; rready = 1;
    for (int t = 0; t < 20 && ok; t++) begin
      @(negedge clk);
      if (rvalid) begin data = rdata; ok = 1; break; end
      ok = (t < 19);
    end
    check("rd_handshake", ok, 1);
    @(posedge clk); #1;
    rready = 0;
  endtask

  task automatic stream(input int err_beat);
    bit ok;
    for (int i = 0; i < 32; i++) begin
      ss_tdata  = (i < 16) ? 32'(i + 1) : 32'(i - 14);
      ss_tlast  = (i == 31) || (i == err_beat);
      ss_tvalid = 1;
      ok = 0;
      for (int t = 0; t < 200; t++) begin
        @(negedge clk);
        if (ss_tready) begin ok = 1; break; end
      end
      if (!ok) begin
        check("ss_handshake", ok, 1);
        break;
      end
      @(posedge clk); #1;
    end
    ss_tvalid = 0; ss_tlast = 0;
  endtask

  task automatic push_golden();
    int unsigned s;
    for (int m = 0; m < 4; m++)
      for (int n = 0; n < 4; n++) begin
        s = 0;
        for (int k = 0; k < 4; k++) s += (4 * m + k + 2) * (4 * k + n + 1);
        sb.push_back({(m == 3 && n == 3), 32'(s)});
      end
  endtask

  task automatic run(input int err_beat, input bit toggle, input int abort_at, input bit calc_write);
    int          we0, out0, lim;
    logic [31:0] d;
    bit          ok;
    we0 = n_we; out0 = n_out;
    lim = (abort_at != 0) ? abort_at : 16;
    push_golden();
    sm_tready = !toggle;
    fork
      axi_write(12'h000, 32'h1);
      stream(err_beat);
      begin
        repeat (8) @(posedge clk);
        axi_read(12'h000, d);
        check("idle_in_load", d[2], 0);
      end
    join
    fork
      begin
        for (int t = 0; t < 3000; t++) begin
          @(posedge clk); #1;
          if (toggle) sm_tready = ~sm_tready;
          if (n_out - out0 >= lim) break;
        end
      end
      begin
        if (calc_write) begin
          ok = 0;
          for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (mac_en) begin ok = 1; break; end
          end
          check("calc_seen", ok, 1);
          axi_write(12'h000, 32'h1);
        end
      end
    join
    check("beat_count", n_we - we0, 32);
    check("out_count", n_out - out0, lim);
    if (abort_at != 0) begin
      ok = 0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (mac_en) begin ok = 1; break; end
      end
      check("abort_calc_seen", ok, 1);
      #2 rst_n = 0;
      #1;
      check("rst_ss_tready", ss_tready, 0);
      check("rst_sm_tvalid", sm_tvalid, 0);
      check("rst_mac_en", mac_en, 0);
      check("rst_buf_we", buf_we, 0);
      sb.delete();
      repeat (2) @(negedge clk);
      rst_n = 1;
      axi_read(12'h000, d);
      check("ctrl_after_abort", d, 32'h4);
    end else begin
      check("sb_empty", sb.size(), 0);
    end
  endtask

  initial begin
    logic [31:0] d;
    rst_n = 0;
    awvalid = 0; wvalid = 0; awaddr = '0; wdata = '0;
    arvalid = 0; araddr = '0; rready = 0;
    ss_tvalid = 0; ss_tlast = 0; ss_tdata = '0; sm_tready = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ss_tready", ss_tready, 0);
    check("reset_sm_tvalid", sm_tvalid, 0);
    check("reset_awready", awready, 0);
    check("reset_rvalid", rvalid, 0);
    check("reset_mac_en", mac_en, 0);
    @(negedge clk); rst_n = 1;
    axi_read(12'h000, d);
    check("ctrl_reset", d, 32'h4);

    // Writes elsewhere are acked and dropped; unmapped reads return 0.
    axi_write(12'h020, 32'h1);
    repeat (4) @(negedge clk);
    check("stray_write_no_start", ss_tready, 0);
    axi_read(12'h024, d);
    check("unmapped_read", d, 0);

    run(-1, 0, 0, 0);
    axi_read(12'h010, d);
`ifdef MM_CYCLE_CNT_EN
    check("cycle_count", d, 129);
`else
    check("cycle_count", d, 0);
`endif
    axi_read(12'h000, d);
    check("ctrl_done", d, 32'h6);
    axi_read(12'h000, d);
    check("ctrl_done_cleared", d, 32'h4);

    run(-1, 1, 0, 0);
    axi_read(12'h000, d);
    check("ctrl_done_toggle", d, 32'h6);

    run(10, 0, 0, 1);
    repeat (6) @(negedge clk);
    check("calc_write_ignored", ss_tready, 0);
    axi_read(12'h000, d);
    check("ctrl_err", d, 32'hE);
    axi_read(12'h000, d);
    check("ctrl_err_cleared", d, 32'h4);

    run(-1, 0, 7, 0);
    run(-1, 1, 0, 0);
    axi_read(12'h000, d);
    check("ctrl_after_rerun", d, 32'h6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
